// File: rtl/bus_arb_pkg.sv
// Shared types and the round-robin winner function for the host bus arbiter.
package bus_arb_pkg;

    localparam int unsigned MaxHosts = 8;
    localparam int unsigned HostIdW  = 3;

    typedef logic [HostIdW-1:0] host_id_t;

    // First requesting host scanning upward from last+1, wrapping modulo nr_hosts.
    // With no request the previous winner is returned; callers qualify with the request.
    function automatic host_id_t rr_next(input logic [MaxHosts-1:0] req,
                                         input host_id_t            last,
                                         input int unsigned         nr_hosts);
        host_id_t    win;
        logic        found;
        int unsigned idx;
        win   = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= MaxHosts; k++) begin
            idx = (32'(last) + k) % nr_hosts;
            if (!found && (k <= nr_hosts) && req[host_id_t'(idx)]) begin
                win   = host_id_t'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/bus_arb_id_fifo.sv
// Synchronous FIFO of host IDs for transactions granted but not yet answered.
module bus_arb_id_fifo
    import bus_arb_pkg::*;
#(
    parameter  int unsigned Depth = 2,
    localparam int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  host_id_t        din_i,
    input  logic            pop_i,
    output host_id_t        dout_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    localparam int unsigned PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned Entries = 2 ** PtrW;

    host_id_t        mem [Entries];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            push_ok;
    logic            pop_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= din_i;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CntW'(1);
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing the device bus between hosts, routing in-order
// responses back by host ID. Optional per-host counters under BUS_ARB_PERF_EN.
module bus_host_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NrHosts        = 2,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddressWidth   = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NrHosts-1:0]                     host_req_i,
    output logic [NrHosts-1:0]                     host_gnt_o,
    input  logic [NrHosts-1:0][AddressWidth-1:0]   host_addr_i,
    input  logic [NrHosts-1:0]                     host_we_i,
    input  logic [NrHosts-1:0][DataWidth/8-1:0]    host_be_i,
    input  logic [NrHosts-1:0][DataWidth-1:0]      host_wdata_i,
    output logic [NrHosts-1:0]                     host_rvalid_o,
    output logic [DataWidth-1:0]                   host_rdata_o,
    output logic [NrHosts-1:0]                     host_err_o,
    output logic                                   dev_req_o,
    input  logic                                   dev_gnt_i,
    output logic [AddressWidth-1:0]                dev_addr_o,
    output logic                                   dev_we_o,
    output logic [DataWidth/8-1:0]                 dev_be_o,
    output logic [DataWidth-1:0]                   dev_wdata_o,
    input  logic                                   dev_rvalid_i,
    input  logic [DataWidth-1:0]                   dev_rdata_i,
    input  logic                                   dev_err_i,
`ifdef BUS_ARB_PERF_EN
    output logic [NrHosts-1:0][31:0]               perf_grant_o,
    output logic [NrHosts-1:0][31:0]               perf_wait_o,
`endif
    output logic                                   proto_err_o
);

    localparam int unsigned IdW  = $clog2(NrHosts);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    host_id_t        last_q;
    host_id_t        winner;
    host_id_t        fifo_head;
    logic [IdW-1:0]  win_idx;
    logic [IdW-1:0]  head_idx;
    logic            any_req;
    logic            grant;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CntW-1:0] fifo_count;

    // Winner for this cycle from the round-robin pointer.
    always_comb begin
        winner = rr_next(MaxHosts'(host_req_i), last_q, NrHosts);
    end

    assign win_idx  = IdW'(winner);
    assign head_idx = IdW'(fifo_head);
    assign any_req  = |host_req_i;

    // A full ID FIFO blocks new requests even if a response pops this cycle.
    assign dev_req_o    = any_req & ~fifo_full & ~rst_i;
    assign grant        = dev_req_o & dev_gnt_i;
    assign pop          = dev_rvalid_i & ~fifo_empty;

    assign dev_addr_o   = host_addr_i[win_idx];
    assign dev_we_o     = host_we_i[win_idx];
    assign dev_be_o     = host_be_i[win_idx];
    assign dev_wdata_o  = host_wdata_i[win_idx];
    assign host_rdata_o = dev_rdata_i;

    // Steer grant to the winner and the response to the oldest outstanding host.
    always_comb begin
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        host_err_o    = '0;
        for (int unsigned h = 0; h < NrHosts; h++) begin
            host_gnt_o[h]    = grant && (win_idx == IdW'(h));
            host_rvalid_o[h] = pop && (head_idx == IdW'(h));
            host_err_o[h]    = pop && dev_err_i && (head_idx == IdW'(h));
        end
    end

    bus_arb_id_fifo #(
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (grant),
        .din_i   (winner),
        .pop_i   (pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Occupancy never exceeds the configured depth.
    count_in_range: assert property (@(posedge clk_i) disable iff (rst_i)
                                     fifo_count <= CntW'(MaxOutstanding));

    // Round-robin pointer and sticky spurious-response flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q      <= host_id_t'(NrHosts - 1);
            proto_err_o <= 1'b0;
        end else begin
            if (grant) begin
                last_q <= winner;
            end
            if (dev_rvalid_i && fifo_empty) begin
                proto_err_o <= 1'b1;
            end
        end
    end

`ifdef BUS_ARB_PERF_EN
    // Per-host grant and wait counters, wrapping at 2^32.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_grant_o <= '0;
            perf_wait_o  <= '0;
        end else begin
            for (int unsigned h = 0; h < NrHosts; h++) begin
                if (host_gnt_o[h]) begin
                    perf_grant_o[h] <= perf_grant_o[h] + 32'd1;
                end
                if (host_req_i[h] && !host_gnt_o[h]) begin
                    perf_wait_o[h] <= perf_wait_o[h] + 32'd1;
                end
            end
        end
    end
`endif

endmodule
